// File: rtl/nbit_skid_register.sv
// Two-entry skid buffer pipeline slice: registered s_ready and m_valid break both
// the forward (valid/data) and backward (ready) combinational paths.
module nbit_skid_register #(
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic                 ACLK,
  input  logic                 RST,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [REG_WIDTH-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [REG_WIDTH-1:0] m_data,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  logic [REG_WIDTH-1:0] skid_data;
  logic                 in_xfer;
  logic                 out_xfer;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  // State, data and handshake flags all update together so outputs stay registered.
  always_ff @(posedge ACLK) begin
    if (RST) begin
      state     <= EMPTY;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      occupancy <= 2'd0;
      m_data    <= '0;
      skid_data <= '0;
    end else begin
      s_ready <= 1'b1;
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state     <= ONE;
            m_data    <= s_data;
            m_valid   <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_data <= s_data;
          end else if (in_xfer) begin
            state     <= FULL;
            skid_data <= s_data;
            s_ready   <= 1'b0;
            occupancy <= 2'd2;
          end else if (out_xfer) begin
            state     <= EMPTY;
            m_valid   <= 1'b0;
            occupancy <= 2'd0;
          end
        end
        FULL: begin
          // No upstream transfer is possible here because s_ready is low.
          if (out_xfer) begin
            state     <= ONE;
            m_data    <= skid_data;
            occupancy <= 2'd1;
          end else begin
            s_ready <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          m_valid   <= 1'b0;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_skid_register.sv
// Directed and randomized check of nbit_skid_register against a queue-based
// model of a two-deep in-order buffer.
module tb_nbit_skid_register;

  logic        ACLK;
  logic        RST;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [1:0]  occupancy;

  nbit_skid_register #(.REG_WIDTH(32)) dut (
    .ACLK      (ACLK),
    .RST       (RST),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int          cmps = 0;
  int          errs = 0;
  logic [31:0] q[$];
  logic [31:0] outs[$];
  logic [31:0] sent[$];
  bit          rdy_en = 1'b0;
  bit          last_in = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_s_ready();
    return rdy_en && (q.size() < 2);
  endfunction

  // One clock edge: advance the model, then check every output #1 after the edge.
  task automatic tick();
    bit          in_x;
    bit          out_x;
    bit          hold;
    logic [31:0] prev_data;
    in_x      = s_valid && exp_s_ready();
    out_x     = (q.size() != 0) && m_ready;
    hold      = m_valid && !m_ready && !RST;
    prev_data = m_data;
    @(posedge ACLK);
    if (RST) begin
      q.delete();
      rdy_en  = 1'b0;
      last_in = 1'b0;
    end else begin
      if (out_x) outs.push_back(q.pop_front());
      if (in_x) begin
        q.push_back(s_data);
        sent.push_back(s_data);
      end
      rdy_en  = 1'b1;
      last_in = in_x;
    end
    #1;
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("s_ready", 32'(s_ready), 32'(exp_s_ready()));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    if (q.size() != 0) chk("m_data", m_data, q[0]);
    if (hold) chk("stable_m_data", m_data, prev_data);
  endtask

  initial begin
    int budget;
    int target;
    int pushed;
    RST     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    m_ready = 1'b0;

    // Reset held for three edges with an offered word.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_m_data", m_data, 32'h0);
    end
    RST = 1'b0;
    tick();
    chk("post_rst_s_ready", 32'(s_ready), 32'h1);
    chk("post_rst_occ", 32'(occupancy), 32'h0);
    s_valid = 1'b0;
    sent.delete();
    tick();

    // Streaming at full rate.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i);
      tick();
      chk("stream_data", m_data, 32'(i));
      chk("stream_occ", 32'(occupancy), 32'h1);
    end
    s_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(m_valid), 32'h0);

    // Backpressure fill.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA;
    tick();
    chk("fill_occ1", 32'(occupancy), 32'h1);
    s_data = 32'hB;
    tick();
    chk("fill_occ2", 32'(occupancy), 32'h2);
    chk("fill_s_ready", 32'(s_ready), 32'h0);
    s_data = 32'hC;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fill_hold_data", m_data, 32'hA);
      chk("fill_hold_occ", 32'(occupancy), 32'h2);
    end

    // Drain in order with 0xC still offered.
    outs.delete();
    m_ready = 1'b1;
    tick();
    chk("drain_s_ready", 32'(s_ready), 32'h1);
    chk("drain_data_b", m_data, 32'hB);
    tick();
    chk("drain_data_c", m_data, 32'hC);
    s_valid = 1'b0;
    tick();
    chk("drain_count", 32'(outs.size()), 32'h3);
    if (outs.size() == 3) begin
      chk("drain_ord0", outs[0], 32'hA);
      chk("drain_ord1", outs[1], 32'hB);
      chk("drain_ord2", outs[2], 32'hC);
    end

    // Random handshake, 1000 words, upstream holds while not accepted.
    outs.delete();
    sent.delete();
    pushed = 0;
    target = 1000;
    budget = 0;
    while ((outs.size() < target) && (budget < 20000)) begin
      if (!(s_valid && !last_in)) begin
        if (pushed < target && ($urandom % 2) == 1) begin
          s_valid = 1'b1;
          s_data  = $urandom;
        end else begin
          s_valid = 1'b0;
          s_data  = $urandom;
        end
      end
      m_ready = 1'($urandom % 2);
      tick();
      if (last_in) pushed++;
      if (pushed >= target && last_in) s_valid = 1'b0;
      budget++;
    end
    s_valid = 1'b0;
    chk("rand_budget_ok", 32'(budget < 20000), 32'h1);
    chk("rand_out_count", 32'(outs.size()), 32'(target));
    chk("rand_sent_count", 32'(sent.size()), 32'(target));
    for (int i = 0; i < outs.size() && i < sent.size(); i++) begin
      chk("rand_order", outs[i], sent[i]);
    end

    // Reset while FULL discards both entries.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h11;
    tick();
    s_data = 32'h22;
    tick();
    chk("mid_full", 32'(occupancy), 32'h2);
    outs.delete();
    RST     = 1'b1;
    s_valid = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(m_valid), 32'h0);
    chk("mid_rst_occ", 32'(occupancy), 32'h0);
    RST = 1'b0;
    tick();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h33;
    tick();
    chk("mid_first_word", m_data, 32'h33);
    s_valid = 1'b0;
    tick();
    tick();
    chk("mid_out_count", 32'(outs.size()), 32'h1);
    if (outs.size() >= 1) chk("mid_out_word", outs[0], 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
